// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 byte-stream front end:
// ASCII codes, the printable window and the output controller state encoding.
package sha256_pkg;

    localparam int DIGEST_W = 256;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_NUL  = 8'h00;

    // Printable byte window, shared with the input controller.
    localparam logic [7:0] ASCII_PRINT_MIN = 8'd32;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'd126;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        TERM,
        DONE
    } out_state_t;

endpackage

// File: rtl/hex_nibble_enc.sv
// Combinational nibble-to-ASCII-hex encoder; the letter case is chosen at
// elaboration time so one instance serves exactly one output style.
module hex_nibble_enc
    import sha256_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    logic [7:0] letter_base;

    assign letter_base = UPPERCASE ? ASCII_A_UP : ASCII_A_LO;

    always_comb begin
        ascii_o = ASCII_ZERO + {4'd0, nibble_i};
        if (nibble_i > 4'd9) begin
            ascii_o = letter_base + {4'd0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_output_ctrl.sv
// Serialises a captured digest as ASCII hex, most-significant nibble first,
// optionally followed by a NUL terminator, over a valid/ready byte stream.
module hex_output_ctrl
    import sha256_pkg::*;
#(
    parameter int DIGEST_W  = sha256_pkg::DIGEST_W,
    parameter bit UPPERCASE = 1'b0,
    parameter bit TERMINATE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGEST_W-1:0] digest_i,
    input  logic                digest_valid_i,
    output logic [7:0]          data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam int NIBBLES = DIGEST_W / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    out_state_t          state_q, state_d;
    logic [DIGEST_W-1:0] shreg_q, shreg_d;
    logic [DIGEST_W-1:0] shreg_shifted;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          data_q, data_d;
    logic [3:0]          enc_nibble;
    logic [7:0]          enc_ascii;

    // Handshake: a byte moves on any rising edge where valid_o && ready_i.
    // valid_o is decoded from the state register only, so it never follows
    // ready_i combinationally, and data_o/valid_o only change after a
    // transfer, which keeps them stable across stalls.
    assign valid_o = (state_q == SEND) || (state_q == TERM);
    assign busy_o  = valid_o;
    assign done_o  = (state_q == DONE);
    assign data_o  = data_q;

    // The encoder looks one nibble ahead so data_q is ready the cycle after
    // a capture or a transfer.
    assign shreg_shifted = shreg_q << 4;
    assign enc_nibble    = (state_q == IDLE) ? digest_i[DIGEST_W-1 -: 4]
                                             : shreg_shifted[DIGEST_W-1 -: 4];

    hex_nibble_enc #(
        .UPPERCASE(UPPERCASE)
    ) u_enc (
        .nibble_i(enc_nibble),
        .ascii_o (enc_ascii)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (digest_valid_i) begin
                    state_d = SEND;
                    shreg_d = digest_i;
                    cnt_d   = '0;
                    data_d  = enc_ascii;
                end
            end
            SEND: begin
                if (ready_i) begin
                    shreg_d = shreg_shifted;
                    if (cnt_q == LAST_NIB) begin
                        state_d = TERMINATE ? TERM : DONE;
                        data_d  = ASCII_NUL;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        data_d = enc_ascii;
                    end
                end
            end
            TERM: begin
                if (ready_i) begin
                    state_d = DONE;
                    data_d  = ASCII_NUL;
                end
            end
            DONE: begin
                state_d = IDLE;
                data_d  = ASCII_NUL;
            end
            default: begin
                state_d = IDLE;
                data_d  = ASCII_NUL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= ASCII_NUL;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule
